lut_config_loader: RTL and testbench
====================================

# lut_config_loader

Sequences configuration of a bank of `NUM_LUTS` LUT selectors, each taking a `WIDTH`-bit `values` truth table. Configuration arrives as `CHUNK`-bit beats on a valid/ready stream and is assembled in a shadow register. The full bank is committed atomically to the live `values_out` bus, so LUT outputs never see a partially loaded table. The block sits between the configuration source (scan/CSR bridge) and the LUT mux instances.

## Interface
- `INPUTS`, 4, select bits per LUT
- `WIDTH`, `1<<INPUTS`, truth-table bits per LUT
- `NUM_LUTS`, 4, LUTs in the bank
- `CHUNK`, 4, bits per config beat; must divide `WIDTH` evenly (elaboration error otherwise)
- `INIT`, 0, reset value of `values_out`, `NUM_LUTS*WIDTH` bits

Ports (reset is synchronous and active-low):
- `clk`  in  1  sole clock, all state on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  begin a load; honoured only in IDLE
- `abort`  in  1  cancel an in-progress load
- `cfg_data`  in  CHUNK  config beat payload
- `cfg_valid`  in  1  beat present
- `cfg_ready`  out  1  beat accepted when `cfg_valid & cfg_ready`
- `values_out`  out  NUM_LUTS*WIDTH  live truth tables; LUT i uses bits [i*WIDTH +: WIDTH]
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse on commit

## Operation
- Total beats: `BEATS = NUM_LUTS*WIDTH/CHUNK`. The beat counter is `$clog2(BEATS)` bits wide, minimum 1.
- States: IDLE, LOAD, COMMIT.
- IDLE: `cfg_ready=0`. If `start & ~abort`, the counter clears and the block enters LOAD. Beats presented in IDLE are not accepted.
- LOAD: `cfg_ready=1`.
  - Accepted beat k writes `shadow[k*CHUNK +: CHUNK]`, LSB-first: beat 0 goes to LUT 0 bits [CHUNK-1:0].
  - The counter increments per accepted beat.
  - Accepting beat `BEATS-1` moves the block to COMMIT.
  - Stalls (`cfg_valid=0`) are unbounded and do not time out.
- COMMIT: lasts one cycle with `cfg_ready=0`. `values_out <= shadow` and `done <= 1`, then the block enters IDLE.
- Abort:
  - In LOAD: the block goes to IDLE the next cycle. The shadow is discarded and `values_out` is unchanged. A beat handshaken in the same cycle is consumed but discarded, and abort wins even on the last beat.
  - In COMMIT: ignored; the commit completes.
  - In IDLE: no effect. `start & abort` in the same cycle stays in IDLE.
- `start` in LOAD or COMMIT is ignored.
- The shadow is not cleared between loads. Every load writes all bits, so stale data never reaches `values_out`.

## Timing
- Reset values:
  - `values_out=INIT`, `cfg_ready=0`, `busy=0`, `done=0`, state IDLE.
  - Counter and shadow are 0.
  - A reset mid-load or mid-commit returns to IDLE with `values_out=INIT` and no `done` pulse.
- `cfg_ready` and `busy` are registered state decodes with no combinational path from inputs.
- `start` at edge N gives `cfg_ready=1` in cycle N+1.
- The last beat accepted at edge M gives COMMIT in cycle M+1.
- New `values_out` and `done=1` both appear in cycle M+2, exactly one cycle wide, with `busy=0`.
- Minimum load latency is `BEATS+2` cycles from `start` to `done`.
- A new `start` is accepted in the same cycle `done` is high, because state is IDLE then.
- `values_out` changes only at the COMMIT edge or at reset.

## Test plan
- Basic load, `NUM_LUTS=2, WIDTH=16, CHUNK=4`: start, then 8 back-to-back beats 1,2,…,8 -> `values_out=32'h87654321` and `done` pulses one cycle, exactly 10 cycles after `start`. `values_out` stays at INIT=0 until that cycle.
- Backpressure-free stalls: same data with `cfg_valid` toggled 1,0,0,1… -> the same final value. `values_out` is unchanged throughout LOAD, and `done` comes 2 cycles after the 8th handshake.
- Abort: load `32'hFFFFFFFF`, then load 8 beats of 0 but assert `abort` with beat 5 -> next cycle IDLE, no `done`, `values_out` stays `32'hFFFFFFFF`. A following full load of `32'h12345678` commits correctly.
- Abort on last beat and abort in COMMIT: `abort` with beat 8 -> no commit. `abort` in the COMMIT cycle -> commit proceeds and `done` fires.
- Ignored inputs: `cfg_valid=1` in IDLE -> `cfg_ready=0` and nothing is written. `start` pulsed mid-LOAD -> counter is not reset. `start & abort` in IDLE -> `busy` stays 0.
- Reset mid-load after 3 beats with `INIT=32'hA5A5A5A5` -> all outputs at reset values next cycle and `values_out=32'hA5A5A5A5`. A subsequent load counts from beat 0.

Source files
------------

// File: rtl/lut_config_loader.sv
// lut_config_loader: assembles CHUNK-bit config beats into a shadow bank and commits it atomically to values_out.
module lut_config_loader #(
  parameter int INPUTS = 4,
  parameter int WIDTH = 1 << INPUTS,
  parameter int NUM_LUTS = 4,
  parameter int CHUNK = 4,
  parameter logic [NUM_LUTS*WIDTH-1:0] INIT = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CHUNK-1:0]          cfg_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [NUM_LUTS*WIDTH-1:0] values_out,
  output logic                      busy,
  output logic                      done
);
  localparam int BEATS = NUM_LUTS * WIDTH / CHUNK;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  if (WIDTH % CHUNK != 0) begin : g_chunk_check
    $error("CHUNK must divide WIDTH evenly");
  end
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [NUM_LUTS*WIDTH-1:0] shadow;
  // cfg_ready and busy are registered alongside the state so no input reaches them combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      values_out <= INIT;
      cfg_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          state     <= LOAD;
          cnt       <= '0;
          cfg_ready <= 1'b1;
          busy      <= 1'b1;
        end
        LOAD: if (abort) begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end else if (cfg_valid) begin
          shadow[cnt*CHUNK +: CHUNK] <= cfg_data;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= COMMIT;
            cfg_ready <= 1'b0;
          end
        end
        COMMIT: begin
          values_out <= shadow;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader: directed and random loads checked against a transaction-level model every cycle.
module tb_lut_config_loader;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [3:0] cfg_data = '0;
  logic cfg_valid = 1'b0;
  logic cfg_ready, busy, done;
  logic [31:0] values_out;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] cur = INIT;
  lut_config_loader #(.INPUTS(4), .NUM_LUTS(2), .CHUNK(4), .INIT(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .values_out(values_out),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference: a load is a list of accepted nibbles; the live image is their weighted sum at commit
  bit m_on = 1'b0, m_loading = 1'b0, m_commit = 1'b0, m_done = 1'b0;
  logic [3:0] m_q[$];
  logic [31:0] m_live = INIT;
  always @(posedge clk) begin
    m_on = 1'b1;
    if (!rst_n) begin
      m_loading = 1'b0; m_commit = 1'b0; m_done = 1'b0; m_live = INIT;
    end else begin
      m_done = 1'b0;
      if (m_commit) begin
        m_live = '0;
        foreach (m_q[k]) m_live = m_live | (32'(m_q[k]) << (4 * k));
        m_done = 1'b1;
        m_commit = 1'b0;
      end else if (!m_loading) begin
        if (start && !abort) begin m_loading = 1'b1; m_q.delete(); end
      end else if (abort) begin
        m_loading = 1'b0;
      end else if (cfg_valid) begin
        m_q.push_back(cfg_data);
        if (m_q.size() == 8) begin m_loading = 1'b0; m_commit = 1'b1; end
      end
    end
  end
  always @(negedge clk) if (m_on) begin
    chk("model_values_out", values_out, m_live);
    chk("model_cfg_ready", 32'(cfg_ready), 32'(m_loading));
    chk("model_busy", 32'(busy), 32'(m_loading || m_commit));
    chk("model_done", 32'(done), 32'(m_done));
  end
  task automatic load(input logic [31:0] v, input int abort_at, input bit stall, input bit abort_commit, input bit start_mid);
    int k = 0;
    int i = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_after_start", 32'(cfg_ready), 32'd1);
    while (k < 8) begin
      cfg_valid = stall ? (i % 3 == 0) : 1'b1;
      cfg_data = v[k*4 +: 4];
      abort = cfg_valid && (k == abort_at);
      start = start_mid && (k == 3);
      tick();
      i++;
      if (abort) break;
      if (cfg_valid) k++;
      if (k < 8) chk("values_hold_in_load", values_out, cur);
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    if (abort) begin
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(cfg_ready), 32'd0);
      tick();
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_values", values_out, cur);
    end else begin
      abort = abort_commit;
      chk("commit_not_yet_done", 32'(done), 32'd0);
      chk("commit_old_values", values_out, cur);
      tick();
      abort = 1'b0;
      chk("done_pulse", 32'(done), 32'd1);
      chk("new_values", values_out, v);
      chk("busy_at_done", 32'(busy), 32'd0);
      cur = v;
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("reset_values", values_out, 32'hA5A5A5A5);
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cfg_valid = 1'b1;
    cfg_data = 4'h3;
    repeat (3) begin
      tick();
      chk("idle_no_ready", 32'(cfg_ready), 32'd0);
    end
    cfg_valid = 1'b0;
    load(32'h87654321, -1, 1'b0, 1'b0, 1'b0);
    chk("basic_literal", values_out, 32'h87654321);
    load(32'h87654321, -1, 1'b1, 1'b0, 1'b0);
    load(32'hFFFFFFFF, -1, 1'b0, 1'b0, 1'b0);
    load(32'h00000000, 4, 1'b0, 1'b0, 1'b0);
    chk("abort_keeps_ff", values_out, 32'hFFFFFFFF);
    load(32'h12345678, -1, 1'b1, 1'b0, 1'b0);
    load(32'h00000000, 7, 1'b0, 1'b0, 1'b0);
    chk("abort_last_beat", values_out, 32'h12345678);
    load(32'hCAFEBABE, -1, 1'b0, 1'b1, 1'b0);
    load(32'h13579BDF, -1, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin cfg_data = 4'(k + 9); tick(); end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cur = INIT;
    chk("midload_reset_values", values_out, 32'hA5A5A5A5);
    chk("midload_reset_busy", 32'(busy), 32'd0);
    chk("midload_reset_ready", 32'(cfg_ready), 32'd0);
    chk("midload_reset_done", 32'(done), 32'd0);
    load(32'h0F1E2D3C, -1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      cfg_valid = $urandom_range(0, 1) == 1;
      cfg_data = 4'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_valid = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
